// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one single-read/single-write regfile among NREQ requesters.
// Optional read-after-write bypass on same-cycle collisions: define RF_ARB_BYPASS_EN.
module regfile_arbiter #(
    parameter int N     = 32,
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            rd_valid,
    input  logic [NREQ*$clog2(N)-1:0]  rd_addr,
    output logic [NREQ-1:0]            rd_ready,
    output logic [NREQ-1:0]            rd_rsp_valid,
    output logic [WIDTH-1:0]           rd_rsp_data,
    input  logic [NREQ-1:0]            wr_valid,
    input  logic [NREQ*$clog2(N)-1:0]  wr_addr,
    input  logic [NREQ*WIDTH-1:0]      wr_data,
    output logic [NREQ-1:0]            wr_ready,
    output logic                       rf_R_en,
    output logic [$clog2(N)-1:0]       rf_R_addr,
    input  logic [WIDTH-1:0]           rf_R_data,
    output logic                       rf_W_en,
    output logic [$clog2(N)-1:0]       rf_W_addr,
    output logic [WIDTH-1:0]           rf_W_data
);

    localparam int AW = $clog2(N);
    localparam int PW = $clog2(NREQ);

    // First requesting index at or after ptr (wrapping); MSB of the result is the hit flag.
    function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] req, input logic [PW-1:0] ptr);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            if (!res[PW] && req[idx]) begin
                res = {1'b1, PW'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] gnt);
        return (int'(gnt) == NREQ - 1) ? PW'(0) : gnt + PW'(1);
    endfunction

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_gnt_s, wr_gnt_s;
    logic            rd_hit_s, wr_hit_s;
    logic [NREQ-1:0] rsp_valid_q;

    // Read and write grant selection plus regfile pin muxing.
    always_comb begin
        {rd_hit_s, rd_gnt_s} = rr_pick(rd_valid, rd_ptr_q);
        {wr_hit_s, wr_gnt_s} = rr_pick(wr_valid, wr_ptr_q);
        rd_ready  = '0;
        wr_ready  = '0;
        rf_R_addr = '0;
        rf_W_addr = '0;
        rf_W_data = '0;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        if (rd_hit_s) begin
            rd_ready[rd_gnt_s] = 1'b1;
            rf_R_addr          = rd_addr[int'(rd_gnt_s)*AW +: AW];
            rd_ptr_d           = ptr_next(rd_gnt_s);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (wr_hit_s) begin
            wr_ready[wr_gnt_s] = 1'b1;
            rf_W_addr          = wr_addr[int'(wr_gnt_s)*AW +: AW];
            rf_W_data          = wr_data[int'(wr_gnt_s)*WIDTH +: WIDTH];
            wr_ptr_d           = ptr_next(wr_gnt_s);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    assign rf_R_en      = rd_hit_s;
    assign rf_W_en      = wr_hit_s;
    assign rd_rsp_valid = rsp_valid_q;

    // Arbiter pointers and the one-cycle response id pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rsp_valid_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rsp_valid_q <= rd_ready;
        end
    end

`ifdef RF_ARB_BYPASS_EN
    logic             byp_q;
    logic [WIDTH-1:0] byp_data_q;

    // Capture write data when a read and write hit the same entry on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else if (rd_hit_s && wr_hit_s && (rf_R_addr == rf_W_addr)) begin
            byp_q      <= 1'b1;
            byp_data_q <= rf_W_data;
        end else begin
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end
    end

    // Response data: bypassed write value wins over the regfile's pre-write read.
    always_comb begin
        if (|rsp_valid_q) begin
            rd_rsp_data = byp_q ? byp_data_q : rf_R_data;
        end else begin
            rd_rsp_data = '0;
        end
    end
`else
    // Response data straight from the regfile, zero when no response is due.
    always_comb begin
        if (|rsp_valid_q) begin
            rd_rsp_data = rf_R_data;
        end else begin
            rd_rsp_data = '0;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter (NREQ=2) with a behavioural regfile and a response scoreboard.
module tb_regfile_arbiter;

    localparam int N     = 32;
    localparam int WIDTH = 32;
    localparam int NREQ  = 2;
    localparam int AW    = 5;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       rd_valid, rd_ready, rd_rsp_valid, wr_valid, wr_ready;
    logic [NREQ*AW-1:0]    rd_addr, wr_addr;
    logic [NREQ*WIDTH-1:0] wr_data;
    logic [WIDTH-1:0]      rd_rsp_data, rf_R_data, rf_W_data;
    logic                  rf_R_en, rf_W_en;
    logic [AW-1:0]         rf_R_addr, rf_W_addr;

    logic [WIDTH-1:0]      mem [N];
    logic [33:0]           exp_q [$];
    int                    tests = 0;
    int                    fails = 0;

    regfile_arbiter #(.N(N), .WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rf_R_en(rf_R_en), .rf_R_addr(rf_R_addr), .rf_R_data(rf_R_data),
        .rf_W_en(rf_W_en), .rf_W_addr(rf_W_addr), .rf_W_data(rf_W_data)
    );

    always #5 clk = ~clk;

    // Behavioural regfile: write commits on the edge, read data is the pre-write value next cycle.
    always @(posedge clk) begin
        if (rf_W_en) mem[rf_W_addr] <= rf_W_data;
        if (rf_R_en) rf_R_data <= mem[rf_R_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every entry queued is due at this negedge; anything else is unexpected.
    always @(negedge clk) begin
        logic [33:0] e;
        if (rd_rsp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", {30'd0, rd_rsp_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_valid", {30'd0, rd_rsp_valid}, {30'd0, e[33:32]});
                chk("rsp_data", rd_rsp_data, e[31:0]);
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("missing_rsp", {30'd0, rd_rsp_valid}, {30'd0, e[33:32]});
        end
    end

    // One cycle of stimulus: drive at negedge, check grants and pins, queue the expected response.
    task automatic drive(input logic [1:0] rv, input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic [1:0] wv, input logic [4:0] wa0, input logic [4:0] wa1,
                         input logic [31:0] wd0, input logic [31:0] wd1,
                         input logic [1:0] exp_rr, input logic [1:0] exp_wr,
                         input logic want_rsp, input logic [31:0] exp_data);
        logic [4:0]  era, ewa;
        logic [31:0] ewd;
        @(negedge clk);
        rd_valid = rv; rd_addr = {ra1, ra0};
        wr_valid = wv; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
        #1;
        era = (exp_rr == 2'b01) ? ra0 : (exp_rr == 2'b10) ? ra1 : 5'd0;
        ewa = (exp_wr == 2'b01) ? wa0 : (exp_wr == 2'b10) ? wa1 : 5'd0;
        ewd = (exp_wr == 2'b01) ? wd0 : (exp_wr == 2'b10) ? wd1 : 32'd0;
        chk("rd_ready", {30'd0, rd_ready}, {30'd0, exp_rr});
        chk("wr_ready", {30'd0, wr_ready}, {30'd0, exp_wr});
        chk("rf_R_en", {31'd0, rf_R_en}, {31'd0, |rv});
        chk("rf_R_addr", {27'd0, rf_R_addr}, {27'd0, era});
        chk("rf_W_en", {31'd0, rf_W_en}, {31'd0, |wv});
        chk("rf_W_addr", {27'd0, rf_W_addr}, {27'd0, ewa});
        chk("rf_W_data", rf_W_data, ewd);
        if (want_rsp) exp_q.push_back({exp_rr, exp_data});
        @(posedge clk);
    endtask

    task automatic idle();
        drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 32'd0);
    endtask

    initial begin
        logic [31:0] coll_exp;
        for (int i = 0; i < N; i++) mem[i] = 32'd0;
        rst_n = 1'b0; rf_R_data = 32'd0;
        rd_valid = 2'b00; rd_addr = '0; wr_valid = 2'b00; wr_addr = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", {30'd0, rd_rsp_valid}, 32'd0);
        chk("reset_rsp_data", rd_rsp_data, 32'd0);
        rst_n = 1'b1;
        idle();

        // Preload: addr5=DEADBEEF (req1), addr7=0x22 (req0), addr9=0xAA (req1).
        drive(2'b00, 5'd0, 5'd0, 2'b10, 5'd0, 5'd5, 32'd0, 32'hDEADBEEF, 2'b00, 2'b10, 1'b0, 32'd0);
        drive(2'b00, 5'd0, 5'd0, 2'b11, 5'd7, 5'd1, 32'h22, 32'h1, 2'b00, 2'b01, 1'b0, 32'd0);
        drive(2'b00, 5'd0, 5'd0, 2'b10, 5'd0, 5'd9, 32'd0, 32'hAA, 2'b00, 2'b10, 1'b0, 32'd0);

        // Read in flight killed by reset: pointers advanced, response must never appear.
        drive(2'b10, 5'd0, 5'd5, 2'b01, 5'd1, 5'd0, 32'h1, 32'd0, 2'b10, 2'b01, 1'b0, 32'd0);
        #1 rst_n = 1'b0;
        rd_valid = 2'b00; wr_valid = 2'b00;
        @(negedge clk);
        chk("rst_rd_ready", {30'd0, rd_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rd_rsp_valid}, 32'd0);
        chk("rst_rsp_data", rd_rsp_data, 32'd0);
        chk("rst_rf_R_en", {31'd0, rf_R_en}, 32'd0);
        rst_n = 1'b1;
        idle();

        // First grant after reset goes to req0; single read of DEADBEEF.
        drive(2'b11, 5'd5, 5'd7, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b01, 2'b00, 1'b1, 32'hDEADBEEF);
        drive(2'b10, 5'd0, 5'd7, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b10, 2'b00, 1'b1, 32'h22);

        // Round robin, back-to-back responses.
        for (int c = 0; c < 6; c++) begin
            if (c % 2 == 0)
                drive(2'b11, 5'd5, 5'd7, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b01, 2'b00, 1'b1, 32'hDEADBEEF);
            else
                drive(2'b11, 5'd5, 5'd7, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b10, 2'b00, 1'b1, 32'h22);
        end

        // Concurrent: req0 writes 0x11 to addr3, req1 reads addr7.
        drive(2'b10, 5'd0, 5'd7, 2'b01, 5'd3, 5'd0, 32'h11, 32'd0, 2'b10, 2'b01, 1'b1, 32'h22);
        drive(2'b01, 5'd3, 5'd0, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b01, 2'b00, 1'b1, 32'h11);

        // Collision on addr9: read by req0, write 0x55 by req1.
`ifdef RF_ARB_BYPASS_EN
        coll_exp = 32'h55;
`else
        coll_exp = 32'hAA;
`endif
        drive(2'b01, 5'd9, 5'd0, 2'b10, 5'd0, 5'd9, 32'd0, 32'h55, 2'b01, 2'b10, 1'b1, coll_exp);
        drive(2'b10, 5'd0, 5'd9, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b10, 2'b00, 1'b1, 32'h55);

        // Pointer hold: req1 alone, three idle cycles, then both -> req0.
        drive(2'b10, 5'd0, 5'd5, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b10, 2'b00, 1'b1, 32'hDEADBEEF);
        repeat (3) idle();
        drive(2'b11, 5'd3, 5'd9, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b01, 2'b00, 1'b1, 32'h11);

        // Write pointer: both write after req1's last write -> req0 then req1.
        drive(2'b00, 5'd0, 5'd0, 2'b11, 5'd12, 5'd13, 32'hC0, 32'hD0, 2'b00, 2'b01, 1'b0, 32'd0);
        drive(2'b00, 5'd0, 5'd0, 2'b11, 5'd12, 5'd13, 32'hC0, 32'hD0, 2'b00, 2'b10, 1'b0, 32'd0);
        drive(2'b11, 5'd12, 5'd13, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b10, 2'b00, 1'b1, 32'hD0);
        drive(2'b01, 5'd12, 5'd13, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b01, 2'b00, 1'b1, 32'hC0);

        repeat (3) idle();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares one `regfile` instance between NREQ requesters. Each requester has independent read and write channels using valid/ready handshakes.
- Runs separate round-robin arbiters for the read port and the write port, so at most one read and one write issue per cycle.
- Drives the regfile's R_*/W_* pins directly and returns read data to the granted requester with a one-hot response valid.

Parameters:
- N, 32: regfile entries; AW = $clog2(N) is derived, not overridable.
- WIDTH, 32: data width.
- NREQ, 2: number of requesters, 2..8.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_valid  in  NREQ  read request per requester.
- rd_addr  in  NREQ*AW  read address; requester i occupies bits [i*AW +: AW].
- rd_ready  out  NREQ  read grant, one-hot or zero.
- rd_rsp_valid  out  NREQ  read response strobe, one-hot or zero.
- rd_rsp_data  out  WIDTH  read response data, shared by all requesters.
- wr_valid  in  NREQ  write request per requester.
- wr_addr  in  NREQ*AW  write address per requester.
- wr_data  in  NREQ*WIDTH  write data per requester.
- wr_ready  out  NREQ  write grant, one-hot or zero.
- rf_R_en  out  1  to regfile R_en.
- rf_R_addr  out  AW  to regfile R_addr.
- rf_R_data  in  WIDTH  from regfile R_data; valid the cycle after R_en is sampled.
- rf_W_en  out  1  to regfile W_en.
- rf_W_addr  out  AW  to regfile W_addr.
- rf_W_data  out  WIDTH  to regfile W_data.

Behaviour:
- Reset, asynchronous on rst_n low:
  - rd_ptr=0, wr_ptr=0.
  - Response stage cleared: rd_rsp_valid=0, rd_rsp_data=0.
  - Combinational outputs are 0 while all valids are low.
  - Any in-flight read response is dropped and never presented.
- Read arbitration, combinational:
  - Scan requesters starting at rd_ptr, wrapping modulo NREQ; the first i with rd_valid[i]=1 gets rd_ready[i]=1.
  - rf_R_en = |rd_valid. rf_R_addr = rd_addr of the granted requester; rf_R_addr=0 when none is granted.
  - A transfer occurs when rd_valid[i] and rd_ready[i] are both high.
  - On a transfer to i: rd_ptr <= (i+1) mod NREQ. With no transfer, rd_ptr holds.
- Write arbitration: identical scheme with wr_ptr and wr_ready.
  - rf_W_en = |wr_valid.
  - rf_W_addr and rf_W_data are muxed from the granted requester; both are 0 when none is granted.
  - The regfile commits the write at the same posedge as the handshake.
- Read and write arbiters are independent. Both may grant in the same cycle, to the same or different requesters.
- Read response, fixed latency 1:
  - A read handshake at posedge k registers the granted one-hot id.
  - In cycle k+1, rd_rsp_valid = that one-hot and rd_rsp_data = rf_R_data. Both are 0 when no read was granted.
  - There is no response backpressure; requesters must accept the response.
  - Back-to-back reads every cycle are supported: full throughput, one response per cycle.
- Same-cycle read and write to the same address, without the optional feature: the response returns the pre-write value, per regfile semantics.
- Requesters must hold valid, addr and data stable until ready. The arbiter does not check this.
- Fairness: with all requesters continuously valid, each is granted exactly once every NREQ cycles on each port.

Optional Feature:
- Macro name: RF_ARB_BYPASS_EN.
- When defined:
  - If a read handshake and a write handshake occur at the same posedge with rf_R_addr == rf_W_addr, register a bypass flag and the write data.
  - In the response cycle, rd_rsp_data = the registered write data instead of rf_R_data, i.e. the read sees the new value.
  - Flag and data clear on reset and in any cycle without a matching collision.
- When undefined: no bypass logic is present, and responses always take rf_R_data.

Test Plan:
- Reset: assert rst_n=0 mid-stream with a read in flight, release, then idle → all outputs 0, no rd_rsp_valid pulse, and the first grant after release goes to requester 0.
- Single read: after writing 0xDEADBEEF to addr 5 via requester 1, requester 0 reads addr 5 → rd_ready=2'b01 in cycle k; in k+1 rd_rsp_valid=2'b01 and rd_rsp_data=0xDEADBEEF.
- Round-robin: both requesters hold rd_valid for 6 cycles (NREQ=2) → grants alternate 01,10,01,10,01,10, and each response lands on the matching requester one cycle later.
- Concurrent ports: requester 0 writes 0x11 to addr 3 while requester 1 reads addr 7 (holding 0x22) in the same cycle → both granted; in the next cycle rd_rsp_valid=2'b10 and rd_rsp_data=0x22, and addr 3 later reads back 0x11.
- Collision: addr 9 holds 0xAA; in one cycle, read addr 9 and write 0x55 to addr 9 → response is 0x55 with RF_ARB_BYPASS_EN defined and 0xAA without; a subsequent read returns 0x55 in both builds.
- Pointer hold: requester 1 alone issues a read, then 3 idle cycles, then both request → the grant goes to requester 0 (rd_ptr=0 after granting requester 1, unchanged through idle).
